// File: rtl/inverter_bank_pkg.sv
// Shared types and constants for the inverter_bank channel filter.
// Counter width helper, default polarity and per-channel filter state.
package inverter_bank_pkg;

    localparam int CNT_MAX_W = 8;

    localparam logic MASK_RST_BIT = 1'b1;

    function automatic int cnt_width(input int filt);
        int w;
        w = $clog2(filt);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic                 filt;
        logic [CNT_MAX_W-1:0] cnt;
    } chan_state_t;

endpackage

// File: rtl/inverter_bank_chan.sv
// One inverter_bank channel: input sample path plus consecutive-sample glitch filter.
// Define INVERTER_BANK_SYNC_EN to put a two-flop synchroniser in front of the filter.
module inverter_bank_chan
    import inverter_bank_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic filt,
    output logic filt_next
);

    if (FILT < 1 || cnt_width(FILT) > CNT_MAX_W) begin : g_bad_filt
        $error("inverter_bank_chan: FILT out of range");
    end

    logic        s_q, s_d;
    chan_state_t st_q, st_d;

`ifdef INVERTER_BANK_SYNC_EN
    logic meta_q, meta_d;

    always_comb begin
        meta_d = in_raw;
        s_d    = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) meta_q <= 1'b0;
        else     meta_q <= meta_d;
    end
`else
    always_comb begin
        s_d = in_raw;
    end
`endif

    // A new level is accepted only after FILT consecutive disagreeing samples.
    always_comb begin
        st_d = st_q;
        if (s_q == st_q.filt) begin
            st_d.cnt = '0;
        end else if (st_q.cnt == CNT_MAX_W'(FILT - 1)) begin
            st_d.filt = s_q;
            st_d.cnt  = '0;
        end else begin
            st_d.cnt = st_q.cnt + CNT_MAX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= 1'b0;
            st_q <= '0;
        end else begin
            s_q  <= s_d;
            st_q <= st_d;
        end
    end

    assign filt      = st_q.filt;
    assign filt_next = st_d.filt;

endmodule

// File: rtl/inverter_bank.sv
// WIDTH-channel filtered inverter bank with programmable polarity mask and change pulses.
// Optional INVERTER_BANK_SYNC_EN adds a two-flop synchroniser per channel.
module inverter_bank
    import inverter_bank_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               FILT     = 3,
    parameter logic [WIDTH-1:0] MASK_RST = {WIDTH{MASK_RST_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] mask_data,
    input  logic             mask_valid,
    output logic             mask_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] changed
);

    logic [WIDTH-1:0] filt, filt_next;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic             ready_q, ready_d;
    logic             accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        inverter_bank_chan #(.FILT(FILT)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_raw    (in[i]),
            .filt      (filt[i]),
            .filt_next (filt_next[i])
        );
    end

    // ready_q resets high; gating with rst keeps the port low only while reset is held.
    assign mask_ready = ready_q & ~rst;
    assign accept     = mask_valid & mask_ready;

    // changed compares next out against current out, so a coincident filter
    // flip and mask flip on one bit cancel out.
    always_comb begin
        mask_d    = accept ? mask_data : mask_q;
        ready_d   = ~accept;
        changed_d = (filt_next ^ mask_d) ^ (filt ^ mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= MASK_RST;
            ready_q   <= 1'b1;
            changed_q <= '0;
        end else begin
            mask_q    <= mask_d;
            ready_q   <= ready_d;
            changed_q <= changed_d;
        end
    end

    assign out     = filt ^ mask_q;
    assign changed = changed_q;

endmodule
